// File: rtl/sample_fifo_argmax_reader.sv
// Streams one classification set out of a sample FIFO and reports the signed
// maximum score with its label index; can rewind the FIFO for a repeat pass.
module sample_fifo_argmax_reader #(
  parameter int FIFO_WIDTH = 16,
  parameter int NUM_LABELS = 1000,
  parameter int IDX_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_replay,
  input  logic                  i_abort,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [IDX_WIDTH-1:0]  o_label,
  output logic [FIFO_WIDTH-1:0] o_score,
  output logic                  o_fifo_pop,
  output logic                  o_fifo_mark_read_rst,
  output logic                  o_fifo_read_rst,
  output logic                  o_fifo_flush,
  input  logic [FIFO_WIDTH-1:0] i_fifo_front,
  input  logic                  i_fifo_vld,
  input  logic                  i_fifo_empty
);

  localparam int CNT_W = $clog2(NUM_LABELS + 1);
  localparam logic [CNT_W-1:0] SET_LEN = CNT_W'(NUM_LABELS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MARK   = 3'd1,
    S_READ   = 3'd2,
    S_DRAIN  = 3'd3,
    S_REWIND = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        issued_q, issued_d;
  logic [CNT_W-1:0]        received_q, received_d;
  logic                    replay_q, replay_d;
  logic [FIFO_WIDTH-1:0]   max_q, max_d;
  logic [IDX_WIDTH-1:0]    idx_q, idx_d;
  logic [IDX_WIDTH-1:0]    label_q, label_d;
  logic [FIFO_WIDTH-1:0]   score_q, score_d;

  logic sample_ok_s;
  logic all_rx_s;
  logic pop_s, mark_s, rrst_s, flush_s, done_s, busy_s;

  // Next-state, datapath update and FIFO control decode.
  always_comb begin
    state_d    = state_q;
    issued_d   = issued_q;
    received_d = received_q;
    replay_d   = replay_q;
    max_d      = max_q;
    idx_d      = idx_q;
    label_d    = label_q;
    score_d    = score_q;
    pop_s      = 1'b0;
    mark_s     = 1'b0;
    rrst_s     = 1'b0;
    flush_s    = 1'b0;
    done_s     = 1'b0;
    busy_s     = 1'b0;

    // Data returning from the FIFO only counts while a pass is collecting it.
    sample_ok_s = i_fifo_vld && ((state_q == S_READ) || (state_q == S_DRAIN));
    if (sample_ok_s) begin
      received_d = received_q + CNT_W'(1);
      // Strict compare keeps the earliest index on ties.
      if ((received_q == '0) || ($signed(i_fifo_front) > $signed(max_q))) begin
        max_d = i_fifo_front;
        idx_d = IDX_WIDTH'(received_q);
      end else begin
        max_d = max_q;
      end
    end else begin
      received_d = received_q;
    end
    all_rx_s = (received_d == SET_LEN);

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d  = S_MARK;
          replay_d = i_replay;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MARK: begin
        busy_s     = 1'b1;
        mark_s     = 1'b1;
        issued_d   = '0;
        received_d = '0;
        state_d    = S_READ;
      end
      S_READ: begin
        busy_s = 1'b1;
        if (!i_fifo_empty && (issued_q < SET_LEN)) begin
          pop_s    = 1'b1;
          issued_d = issued_q + CNT_W'(1);
        end else begin
          pop_s = 1'b0;
        end
        if (all_rx_s) begin
          state_d = replay_q ? S_REWIND : S_DONE;
        end else if (issued_d == SET_LEN) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_READ;
        end
      end
      S_DRAIN: begin
        busy_s = 1'b1;
        if (all_rx_s) begin
          state_d = replay_q ? S_REWIND : S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_REWIND: begin
        busy_s  = 1'b1;
        rrst_s  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        done_s  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Result registers load on entry to DONE so they are valid with the pulse.
    if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      label_d = idx_d;
      score_d = max_d;
    end else begin
      label_d = label_q;
      score_d = score_q;
    end

    // Abort overrides everything; the flush is the only FIFO control that cycle.
    if (i_abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      pop_s   = 1'b0;
      mark_s  = 1'b0;
      rrst_s  = 1'b0;
      done_s  = 1'b0;
      flush_s = 1'b1;
      label_d = label_q;
      score_d = score_q;
    end else begin
      flush_s = 1'b0;
    end
  end

  // State, counters, running maximum and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      issued_q   <= '0;
      received_q <= '0;
      replay_q   <= 1'b0;
      max_q      <= '0;
      idx_q      <= '0;
      label_q    <= '0;
      score_q    <= '0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      received_q <= received_d;
      replay_q   <= replay_d;
      max_q      <= max_d;
      idx_q      <= idx_d;
      label_q    <= label_d;
      score_q    <= score_d;
    end
  end

  assign o_busy               = busy_s;
  assign o_done               = done_s;
  assign o_label              = label_q;
  assign o_score              = score_q;
  assign o_fifo_pop           = pop_s;
  assign o_fifo_mark_read_rst = mark_s;
  assign o_fifo_read_rst      = rrst_s;
  assign o_fifo_flush         = flush_s;

endmodule

// File: doc/sample_fifo_argmax_reader.md
SAMPLE_FIFO_ARGMAX_READER -- requirements
Module: sample_fifo_argmax_reader

Interface
REQ-001 Parameter FIFO_WIDTH, default 16, sets the score width; scores are signed two's complement.
REQ-002 Parameter NUM_LABELS, default 1000, sets the number of scores per classification set.
REQ-003 Parameter IDX_WIDTH, default 10, sets the label index width; it SHALL satisfy 2**IDX_WIDTH >= NUM_LABELS.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 i_start  in  1  one-cycle request to evaluate one set.
REQ-007 i_replay  in  1  sampled with i_start; 1 means rewind the FIFO read pointer after the pass.
REQ-008 i_abort  in  1  terminates any pass in progress.
REQ-009 o_busy  out  1  high from accepted start until done or abort.
REQ-010 o_done  out  1  one-cycle pulse when the result is valid.
REQ-011 o_label  out  IDX_WIDTH  index of the maximum score.
REQ-012 o_score  out  FIFO_WIDTH  maximum score value.
REQ-013 o_fifo_pop  out  1  pop request to the sample FIFO.
REQ-014 o_fifo_mark_read_rst  out  1  marks the read-pointer rewind point.
REQ-015 o_fifo_read_rst  out  1  rewinds the read pointer to the mark.
REQ-016 o_fifo_flush  out  1  empties the FIFO.
REQ-017 i_fifo_front  in  FIFO_WIDTH  popped data.
REQ-018 i_fifo_vld  in  1  i_fifo_front valid; it arrives exactly 1 cycle after the pop.
REQ-019 i_fifo_empty  in  1  FIFO empty.

Function
REQ-020 The FSM SHALL have states IDLE, MARK, READ, DRAIN, REWIND and DONE.
REQ-021 IDLE -> MARK on i_start; i_start while o_busy=1 SHALL be ignored.
REQ-022 MARK SHALL hold o_fifo_mark_read_rst=1 for exactly 1 cycle, latch i_replay, clear both counters, and move to READ.
REQ-023 READ: o_fifo_pop = !i_fifo_empty && (issued < NUM_LABELS), combinational from state, issued and i_fifo_empty; the issued counter increments per pop.
REQ-024 READ -> DRAIN when issued reaches NUM_LABELS; DRAIN waits until received == NUM_LABELS.
REQ-025 The received counter increments on each i_fifo_vld in READ or DRAIN; i_fifo_vld in any other state SHALL be ignored.
REQ-026 The first received sample (index 0) SHALL load the running max and index unconditionally.
REQ-027 Later samples SHALL replace the running max only when strictly greater (signed), so on a tie the lowest index wins.
REQ-028 The index of each sample is the received count before its increment, width IDX_WIDTH.
REQ-029 All samples received -> REWIND if replay is latched, otherwise -> DONE.
REQ-030 REWIND SHALL hold o_fifo_read_rst=1 for exactly 1 cycle, then go to DONE.
REQ-031 DONE SHALL pulse o_done for 1 cycle, register o_label/o_score, and return to IDLE.
REQ-032 o_label/o_score SHALL hold their value until the next o_done.
REQ-033 o_busy=1 in MARK, READ, DRAIN and REWIND; o_busy=0 in DONE and IDLE.
REQ-034 Result latency: o_done is 1 cycle after the last i_fifo_vld without replay, or 2 cycles with replay.
REQ-035 While i_fifo_empty=1 the block SHALL stall in READ with no pops and no timeout.
REQ-036 i_abort in any state except IDLE SHALL pulse o_fifo_flush for 1 cycle and go to IDLE, with no o_done and outputs unchanged.
REQ-037 i_abort has priority over all other transitions in the same cycle; i_abort in IDLE SHALL have no effect.
REQ-038 At most one of o_fifo_pop, o_fifo_mark_read_rst, o_fifo_read_rst and o_fifo_flush SHALL be high in any cycle.

Reset
REQ-039 rst_n=0 SHALL immediately force IDLE, clear counters, and set all outputs to 0 (o_label=0, o_score=0, all FIFO controls 0).
REQ-040 Reset asserted mid-pass SHALL abandon the pass without an o_done or FIFO control pulse.

Verification
REQ-041 NUM_LABELS=4, scores {3,-2,7,5}, no replay -> o_done with o_label=2, o_score=7; exactly 4 pops, 1 mark, 0 read_rst.
REQ-042 Scores {5,5,-1,5} -> o_label=0, o_score=5 (tie lowest index); all-negative {-8,-3,-9,-3} -> o_label=1, o_score=-3.
REQ-043 Replay=1 -> o_fifo_read_rst pulse 1 cycle after the last vld, o_done the cycle after; a second start on the rewound FIFO gives an identical result.
REQ-044 i_fifo_empty toggles every 3 cycles during READ -> no pop while empty, final result is correct, o_busy stays high throughout.
REQ-045 i_abort after 2 of 4 samples -> 1-cycle o_fifo_flush, IDLE, no o_done, previous o_label/o_score retained.
REQ-046 rst_n low mid-DRAIN -> all outputs 0 the same cycle; a fresh start after release completes normally.
